// File: rtl/shapool_pkg.sv
// Shared definitions for the SHA-256 nonce-search pool job sequencer.
// Holds the sequencer state encoding and the fixed field widths of the
// serial job format (nonce, daisy word, difficulty, default job width).
package shapool_pkg;

  localparam int NONCE_BITS       = 32;
  localparam int DAISY_BITS       = 40;
  localparam int DIFF_BITS        = 8;
  localparam int JOB_BITS_DEFAULT = 352;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EXEC,
    SUCCESS,
    DONE
  } state_t;

endpackage

// File: rtl/shapool_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with rising and
// falling edge detection on the synchronised level.
// Ports:
//   clk      - destination clock
//   reset    - synchronous active-high reset
//   async_in - asynchronous input
//   sync_out - synchronised level (last synchroniser stage)
//   rise     - one-cycle pulse: sync_out high, previous sample low
//   fall     - one-cycle pulse: sync_out low, previous sample high
module shapool_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Synchroniser chain plus one extra flop holding the previous synchronised
  // sample, so edges are judged only on fully synchronised values.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain[0] <= async_in;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      prev <= chain[STAGES-1];
    end
  end

  assign sync_out = chain[STAGES-1];
  assign rise     = chain[STAGES-1] & ~prev;
  assign fall     = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/shapool_control.sv
// Job sequencer for the SHA-256 nonce-search pool.
// Deserialises a job (global job bits plus a 40-bit per-device daisy word)
// from the shared serial bus, starts the hash pool batch by batch while
// stepping the nonce, stops on a match, on nonce exhaustion or on a win by
// another device, and shifts the winning nonce back out on the serial bus.
// Ports:
//   hwclk, reset_in              - pool clock, synchronous active-high reset
//   data_clk, data_in            - async serial clock / global job data
//   daisy_sel, daisy_in          - async load-phase select / daisy data
//   daisy_out                    - daisy register MSB to next device
//   done_in, done_out            - done chain (own done AND upstream done)
//   success_in, success_oe       - shared success line sample / drive enable
//   data_out, data_out_oe        - winning nonce serial output and enable
//   job_data, difficulty, nonce  - job fields presented to the pool
//   core_start                   - pulse: pool starts a batch at nonce
//   core_valid, core_match,
//   core_match_nonce             - batch completion report from the pool
//   status_led, success_led      - searching / found indicators
module shapool_control
  import shapool_pkg::*;
#(
  parameter int POOL_SIZE      = 1,
  parameter int POOL_SIZE_LOG2 = 0,
  parameter int JOB_BITS       = JOB_BITS_DEFAULT,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                  hwclk,
  input  logic                  reset_in,
  input  logic                  data_clk,
  input  logic                  data_in,
  input  logic                  daisy_sel,
  input  logic                  daisy_in,
  output logic                  daisy_out,
  input  logic                  done_in,
  output logic                  done_out,
  input  logic                  success_in,
  output logic                  success_oe,
  output logic                  data_out,
  output logic                  data_out_oe,
  output logic [JOB_BITS-1:0]   job_data,
  output logic [DIFF_BITS-1:0]  difficulty,
  output logic [NONCE_BITS-1:0] nonce,
  output logic                  core_start,
  input  logic                  core_valid,
  input  logic                  core_match,
  input  logic [NONCE_BITS-1:0] core_match_nonce,
  output logic                  status_led,
  output logic                  success_led
);

  localparam logic [NONCE_BITS-1:0] STEP = NONCE_BITS'(1) << POOL_SIZE_LOG2;

  state_t                  state, state_next;
  logic [JOB_BITS-1:0]     job_sr;
  logic [DAISY_BITS-1:0]   daisy_sr;
  logic [NONCE_BITS-1:0]   nonce_r;
  logic [NONCE_BITS-1:0]   result_sr;
  logic                    core_start_r;
  logic [NONCE_BITS:0]     nonce_sum;
  logic                    load_done, batch_match, batch_advance;

  logic data_clk_s, data_clk_rise, data_clk_fall;
  logic data_in_s, data_in_rise, data_in_fall;
  logic daisy_sel_s, daisy_sel_rise, daisy_sel_fall;
  logic daisy_in_s, daisy_in_rise, daisy_in_fall;
  logic done_in_s, done_in_rise, done_in_fall;
  logic success_in_s, success_in_rise, success_in_fall;
  logic unused_sync;

  // Every async input goes through the same synchroniser depth, so serial
  // data stays aligned with the synchronised data_clk edge.
  shapool_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_data_clk (
    .clk(hwclk), .reset(reset_in), .async_in(data_clk),
    .sync_out(data_clk_s), .rise(data_clk_rise), .fall(data_clk_fall));
  shapool_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_data_in (
    .clk(hwclk), .reset(reset_in), .async_in(data_in),
    .sync_out(data_in_s), .rise(data_in_rise), .fall(data_in_fall));
  shapool_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_daisy_sel (
    .clk(hwclk), .reset(reset_in), .async_in(daisy_sel),
    .sync_out(daisy_sel_s), .rise(daisy_sel_rise), .fall(daisy_sel_fall));
  shapool_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_daisy_in (
    .clk(hwclk), .reset(reset_in), .async_in(daisy_in),
    .sync_out(daisy_in_s), .rise(daisy_in_rise), .fall(daisy_in_fall));
  shapool_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_done_in (
    .clk(hwclk), .reset(reset_in), .async_in(done_in),
    .sync_out(done_in_s), .rise(done_in_rise), .fall(done_in_fall));
  shapool_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_success_in (
    .clk(hwclk), .reset(reset_in), .async_in(success_in),
    .sync_out(success_in_s), .rise(success_in_rise), .fall(success_in_fall));

  // Edge outputs that this sequencer has no use for.
  assign unused_sync = ^{data_clk_s, data_clk_fall, data_in_rise, data_in_fall,
                         daisy_in_rise, daisy_in_fall, done_in_rise, done_in_fall,
                         success_in_rise, success_in_fall, (POOL_SIZE != 0)};

  // Bit NONCE_BITS of the widened sum flags that the next batch would wrap.
  assign nonce_sum   = {1'b0, nonce_r} + {1'b0, STEP};
  assign load_done   = (state == LOAD) && daisy_sel_fall;
  assign batch_match = (state == EXEC) && core_valid && core_match;
  // A batch finished with nothing higher-priority pending: move on.
  assign batch_advance = (state == EXEC) && core_valid && !core_match &&
                         !daisy_sel_rise && !success_in_s && !nonce_sum[NONCE_BITS];

  always_ff @(posedge hwclk) begin
    if (reset_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // EXEC stop conditions are ordered: own match beats an abort by a new
  // load, which beats another device's win, which beats exhaustion.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (daisy_sel_s) state_next = LOAD;
      LOAD:    if (daisy_sel_fall) state_next = EXEC;
      EXEC: begin
        if (batch_match)                              state_next = SUCCESS;
        else if (daisy_sel_rise)                      state_next = LOAD;
        else if (success_in_s)                        state_next = DONE;
        else if (core_valid && nonce_sum[NONCE_BITS]) state_next = DONE;
      end
      SUCCESS: if (daisy_sel_rise) state_next = LOAD;
      DONE:    if (daisy_sel_rise) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    status_led  = (state == EXEC);
    success_led = (state == SUCCESS);
    success_oe  = (state == SUCCESS);
    data_out_oe = (state == SUCCESS) && !daisy_sel_s;
    data_out    = (state == SUCCESS) && result_sr[NONCE_BITS-1];
    done_out    = (state == DONE) && done_in_s;
  end

  // Job/daisy deserialisation, nonce stepping and result shift-out.
  // core_start is registered so it lines up with the nonce it refers to.
  always_ff @(posedge hwclk) begin
    if (reset_in) begin
      job_sr       <= '0;
      daisy_sr     <= '0;
      nonce_r      <= '0;
      result_sr    <= '0;
      core_start_r <= 1'b0;
    end else begin
      core_start_r <= load_done || batch_advance;
      if ((state == LOAD) && data_clk_rise) begin
        job_sr   <= {job_sr[JOB_BITS-2:0], data_in_s};
        daisy_sr <= {daisy_sr[DAISY_BITS-2:0], daisy_in_s};
      end
      if (load_done) begin
        nonce_r   <= daisy_sr[NONCE_BITS-1:0];
        result_sr <= '0;
      end
      if (batch_advance) begin
        nonce_r <= nonce_sum[NONCE_BITS-1:0];
      end
      if (batch_match) begin
        result_sr <= core_match_nonce;
      end
      if ((state == SUCCESS) && data_clk_rise) begin
        result_sr <= {result_sr[NONCE_BITS-2:0], 1'b0};
      end
    end
  end

  assign job_data   = job_sr;
  assign difficulty = daisy_sr[DAISY_BITS-1 -: DIFF_BITS];
  assign nonce      = nonce_r;
  assign core_start = core_start_r;
  assign daisy_out  = daisy_sr[DAISY_BITS-1];

endmodule
